// File: rtl/hog_pkg.sv
// Shared definitions for the gradient-magnitude pipeline: the default gradient
// width and the state encoding of the magnitude-squared sequencer.
package hog_pkg;

   localparam int G_W_DEFAULT = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQ_X = 2'd1,
      SQ_Y = 2'd2,
      DONE = 2'd3
   } mag_sq_state_t;

endpackage

// File: rtl/mag_sq_if.sv
// Handshake bundle between a gradient producer and mag_sq: a gx/gy request
// channel and a squared-magnitude result channel.
interface mag_sq_if
   import hog_pkg::*;
#(
   parameter int G_W = G_W_DEFAULT
);

   localparam int OUT_W = 2 * G_W;

   logic                    in_valid;
   logic                    in_ready;
   logic signed [G_W-1:0]   gx;
   logic signed [G_W-1:0]   gy;
   logic                    out_valid;
   logic                    out_ready;
   logic        [OUT_W-1:0] out_data;

   modport master (
      output in_valid, gx, gy, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, gx, gy, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/mag_sq_mac.sv
// Bit-serial unsigned square-and-accumulate: operand*operand is added into acc
// one multiplier bit per cycle, LSB first, finishing after exactly G_W cycles.
module mag_sq_mac
   import hog_pkg::*;
#(
   parameter int G_W = G_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               clear,
   input  logic [G_W-1:0]     operand,
   output logic               busy,
   output logic               done,
   output logic [2*G_W-1:0]   acc
);

   localparam int OUT_W = 2 * G_W;
   localparam int CNT_W = $clog2(G_W + 1);

   logic [OUT_W-1:0] acc_q;
   logic [OUT_W-1:0] mcand;
   logic [G_W-1:0]   mplier;
   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic             done_q;
   logic [OUT_W-1:0] base;
   logic [OUT_W-1:0] addend;

   // The start cycle already consumes bit 0, so G_W edges cover all bits.
   always_comb begin
      base   = acc_q;
      addend = '0;
      if (start) begin
         if (clear) begin
            base = '0;
         end
         if (operand[0]) begin
            addend = OUT_W'(operand);
         end
      end else if (busy_q && mplier[0]) begin
         addend = mcand;
      end
   end

   // done is a one-cycle pulse, raised when acc already holds the full sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            acc_q  <= base + addend;
            mcand  <= OUT_W'(operand) << 1;
            mplier <= operand >> 1;
            cnt    <= CNT_W'(1);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            acc_q  <= base + addend;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(G_W - 1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign acc  = acc_q;

endmodule

// File: rtl/mag_sq.sv
// Squared gradient magnitude gx*gx + gy*gy, computed by one shared bit-serial
// MAC that squares |gx| and then accumulates |gy|^2 on top of it.
module mag_sq
   import hog_pkg::*;
#(
   parameter int G_W = G_W_DEFAULT
) (
   input  logic     clk,
   input  logic     rst,
   mag_sq_if.slave  bus
);

   localparam int OUT_W = 2 * G_W;

   mag_sq_state_t    state_q;
   mag_sq_state_t    state_d;
   logic [G_W-1:0]   abs_x;
   logic [G_W-1:0]   abs_y;
   logic [G_W-1:0]   gx_abs;
   logic [G_W-1:0]   gy_abs;
   logic [G_W-1:0]   gx_raw;
   logic [G_W-1:0]   gy_raw;
   logic [OUT_W-1:0] out_data_q;
   logic             mac_start;
   logic             mac_clear;
   logic [G_W-1:0]   mac_operand;
   logic             mac_busy;
   logic             mac_done;
   logic [OUT_W-1:0] mac_acc;

   // Magnitude fits in G_W unsigned bits, so the most negative input needs no clamp.
   always_comb begin
      gx_raw = bus.gx;
      gy_raw = bus.gy;
      gx_abs = gx_raw[G_W-1] ? (~gx_raw + G_W'(1)) : gx_raw;
      gy_abs = gy_raw[G_W-1] ? (~gy_raw + G_W'(1)) : gy_raw;
   end

   // First SQ_X cycle starts |gx|^2 with a cleared accumulator; the MAC's done
   // pulse then restarts it on |gy| without clearing.
   always_comb begin
      state_d     = state_q;
      mac_start   = 1'b0;
      mac_clear   = 1'b0;
      mac_operand = abs_x;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d = SQ_X;
            end
         end
         SQ_X: begin
            if (mac_done) begin
               state_d     = SQ_Y;
               mac_start   = 1'b1;
               mac_operand = abs_y;
            end else if (!mac_busy) begin
               mac_start   = 1'b1;
               mac_clear   = 1'b1;
            end
         end
         SQ_Y: begin
            if (mac_done) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         abs_x      <= '0;
         abs_y      <= '0;
         out_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.in_valid) begin
            abs_x <= gx_abs;
            abs_y <= gy_abs;
         end
         if (state_q == SQ_Y && mac_done) begin
            out_data_q <= mac_acc;
         end
      end
   end

   mag_sq_mac #(
      .G_W (G_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .start   (mac_start),
      .clear   (mac_clear),
      .operand (mac_operand),
      .busy    (mac_busy),
      .done    (mac_done),
      .acc     (mac_acc)
   );

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_mag_sq.sv
// Scoreboard bench for mag_sq: accepted pairs queue gx^2+gy^2, and a negedge
// monitor checks results, latency, stall stability and handshake timing.
module tb_mag_sq;

   localparam int G_W = 9;
   localparam int LAT = 2 * G_W + 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mag_sq_if #(.G_W(G_W)) bus();

   mag_sq #(
      .G_W (G_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int nChecks = 0;
   int nErrors = 0;
   int cyc = 0;
   int expQ[$];
   int acceptCyc = 0;
   bit haveAccept = 0;
   bit prevValid = 0;
   bit stallPrev = 0;
   bit expectReady = 0;
   longint stallData = 0;
   longint heldData = 0;
   int monA;
   int monB;
   int popped;
   bit randDone = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      nChecks++;
      if (actual != expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Offer a pair and wait for the accepting edge; in_valid is left high.
   task automatic applyStimulus(input int x, input int y);
      bus.gx       = G_W'(x);
      bus.gy       = G_W'(y);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) break;
      end
      checkOutput("in_ready_seen", longint'(bus.in_ready), 1);
      @(posedge clk);
      #1;
   endtask

   task automatic waitForOutput();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      checkOutput("out_valid_seen", longint'(bus.out_valid), 1);
   endtask

   task automatic runPair(input int x, input int y);
      applyStimulus(x, y);
      bus.in_valid = 1'b0;
      waitForOutput();
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: compare current outputs first, then update the model for this cycle.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
         heldData    = 0;
         haveAccept  = 0;
         expectReady = 0;
         stallPrev   = 0;
         prevValid   = 0;
      end else begin
         if (expectReady) begin
            checkOutput("in_ready_after_consume", longint'(bus.in_ready), 1);
            checkOutput("out_valid_after_consume", longint'(bus.out_valid), 0);
            checkOutput("out_data_hold", longint'(bus.out_data), heldData);
            expectReady = 0;
         end
         if (bus.out_valid && !prevValid) begin
            if (haveAccept) checkOutput("latency", cyc - acceptCyc, LAT);
            else checkOutput("spurious_out_valid", longint'(bus.out_valid), 0);
         end
         if (bus.out_valid && stallPrev) begin
            checkOutput("stall_out_data_stable", longint'(bus.out_data), stallData);
            checkOutput("stall_in_ready_low", longint'(bus.in_ready), 0);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_result", longint'(bus.out_data), -1);
            end else begin
               popped = expQ.pop_front();
               checkOutput("result", longint'(bus.out_data), popped);
               heldData    = popped;
               expectReady = 1;
            end
         end
         stallPrev = bus.out_valid && !bus.out_ready;
         stallData = longint'(bus.out_data);
         if (bus.in_valid && bus.in_ready) begin
            monA = int'(bus.gx);
            monB = int'(bus.gy);
            expQ.push_back(monA * monA + monB * monB);
            if (haveAccept) checkOutput("accept_spacing_ok", longint'((cyc + 1 - acceptCyc) >= LAT + 1), 1);
            acceptCyc  = cyc + 1;
            haveAccept = 1;
         end
         prevValid = bus.out_valid;
      end
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.gx        = '0;
      bus.gy        = '0;
      bus.out_ready = 1'b0;
      $display("[TB] mag_sq bench start, G_W=%0d", G_W);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_in_ready", longint'(bus.in_ready), 1);
      checkOutput("reset_out_valid", longint'(bus.out_valid), 0);
      checkOutput("reset_out_data", longint'(bus.out_data), 0);
      @(posedge clk);
      #1;

      bus.out_ready = 1'b1;
      runPair(3, 4);
      runPair(-256, -256);
      runPair(255, -255);
      runPair(0, 0);

      // Stalled result: data must hold and a new offer must be ignored.
      bus.out_ready = 1'b0;
      applyStimulus(5, 6);
      bus.in_valid = 1'b0;
      waitForOutput();
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.gx       = G_W'(1);
      bus.gy       = G_W'(0);
      repeat (5) begin
         @(negedge clk);
         checkOutput("stall_out_valid", longint'(bus.out_valid), 1);
         checkOutput("stall_ignored_in_ready", longint'(bus.in_ready), 0);
         checkOutput("stall_out_data", longint'(bus.out_data), 61);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Reset while squaring |gy| aborts the operation.
      applyStimulus(100, 100);
      bus.in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("abort_in_ready", longint'(bus.in_ready), 1);
      checkOutput("abort_out_valid", longint'(bus.out_valid), 0);
      checkOutput("abort_out_data", longint'(bus.out_data), 0);
      repeat (25) begin
         @(negedge clk);
         checkOutput("abort_no_out_valid", longint'(bus.out_valid), 0);
      end
      @(posedge clk);
      #1;
      runPair(-7, 2);

      // Back-to-back random pairs against random downstream back-pressure.
      fork
         begin
            while (!randDone) begin
               @(posedge clk);
               #1 bus.out_ready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      for (int n = 0; n < 40; n++) begin
         applyStimulus(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 500 && expQ.size() > 0; i++) @(posedge clk);
      randDone = 1;
      repeat (2) @(posedge clk);
      #1 bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("queue_drained", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
      $finish;
   end

endmodule
